// File: rtl/rf_fifo_ctrl_pkg.sv
// Shared defaults and sizing helpers for the register-file backed show-ahead FIFO.
package rf_fifo_ctrl_pkg;

    localparam int RF_FIFO_DW_DEF = 32;
    localparam int RF_FIFO_AW_DEF = 3;

    // Number of RF entries addressable with an aw-bit address.
    function automatic int rf_depth(input int aw);
        return 32'sd1 << aw;
    endfunction

endpackage

// File: rtl/rf_fifo_ctrl.sv
// Show-ahead FIFO sequencer around a 1w1r RF with registered read; the RF's
// held read data doubles as the one-entry output stage.
module rf_fifo_ctrl
    import rf_fifo_ctrl_pkg::*;
#(
    parameter int DW = RF_FIFO_DW_DEF,
    parameter int AW = RF_FIFO_AW_DEF
) (
    input  logic          CLK,
    input  logic          RST_N,
    input  logic          FLUSH,
    input  logic          PUSH,
    input  logic [DW-1:0] PUSH_DATA,
    output logic          PUSH_READY,
    output logic          POP_VALID,
    output logic [DW-1:0] POP_DATA,
    input  logic          POP,
    output logic [AW+1:0] COUNT,
    output logic          RF_RE,
    output logic [AW-1:0] RF_RADDR,
    input  logic [DW-1:0] RF_RDATA,
    output logic          RF_WE,
    output logic [AW-1:0] RF_WADDR,
    output logic [DW-1:0] RF_WDATA
);

    localparam logic [AW:0] RF_FULL = (AW+1)'(rf_depth(AW));

    logic [AW-1:0] wptr_r;
    logic [AW-1:0] rptr_r;
    logic [AW:0]   rf_cnt_r;
    logic          out_vld_r;

    logic          push_ready_s;
    logic          acc_w_s;
    logic          acc_p_s;
    logic          rd_s;

    // Handshake decode; full/empty come only from rf_cnt, never pointer compare.
    always_comb begin
        push_ready_s = (rf_cnt_r != RF_FULL);
        acc_w_s      = PUSH & push_ready_s & ~FLUSH;
        acc_p_s      = POP & out_vld_r & ~FLUSH;
        rd_s         = ~FLUSH & (rf_cnt_r != {(AW+1){1'b0}}) & (~out_vld_r | acc_p_s);
    end

    // Pointer, occupancy and output-stage state; FLUSH discards everything.
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            wptr_r    <= {AW{1'b0}};
            rptr_r    <= {AW{1'b0}};
            rf_cnt_r  <= {(AW+1){1'b0}};
            out_vld_r <= 1'b0;
        end else if (FLUSH) begin
            wptr_r    <= {AW{1'b0}};
            rptr_r    <= {AW{1'b0}};
            rf_cnt_r  <= {(AW+1){1'b0}};
            out_vld_r <= 1'b0;
        end else begin
            if (acc_w_s) begin
                wptr_r <= wptr_r + {{(AW-1){1'b0}}, 1'b1};
            end
            if (rd_s) begin
                rptr_r <= rptr_r + {{(AW-1){1'b0}}, 1'b1};
            end
            rf_cnt_r <= rf_cnt_r + {{AW{1'b0}}, acc_w_s} - {{AW{1'b0}}, rd_s};
            if (rd_s) begin
                out_vld_r <= 1'b1;
            end else if (acc_p_s) begin
                out_vld_r <= 1'b0;
            end
        end
    end

    // RF strobes and consumer-facing outputs.
    always_comb begin
        PUSH_READY = push_ready_s;
        POP_VALID  = out_vld_r;
        POP_DATA   = RF_RDATA;
        COUNT      = {1'b0, rf_cnt_r} + {{(AW+1){1'b0}}, out_vld_r};
        RF_WE      = acc_w_s;
        RF_WADDR   = wptr_r;
        RF_WDATA   = PUSH_DATA;
        RF_RE      = rd_s;
        RF_RADDR   = rptr_r;
    end

endmodule

// File: tb/tb_rf_fifo_ctrl.sv
// Randomized + directed bench for rf_fifo_ctrl with a behavioural RF and a
// queue-based FIFO reference model feeding a decoupled pop monitor.
module tb_rf_fifo_ctrl;

    localparam int DW    = 32;
    localparam int AW    = 3;
    localparam int DEPTH = 8;

    logic          CLK = 1'b0;
    logic          RST_N = 1'b0;
    logic          FLUSH = 1'b0;
    logic          PUSH = 1'b0;
    logic [DW-1:0] PUSH_DATA = '0;
    logic          POP = 1'b0;
    logic          PUSH_READY, POP_VALID;
    logic [DW-1:0] POP_DATA;
    logic [AW+1:0] COUNT;
    logic          RF_RE, RF_WE;
    logic [AW-1:0] RF_RADDR, RF_WADDR;
    logic [DW-1:0] RF_WDATA;
    logic [DW-1:0] RF_RDATA;

    logic [DW-1:0] rf_mem [DEPTH];
    logic [DW-1:0] rf_rdata_r = '0;

    rf_fifo_ctrl #(.DW(DW), .AW(AW)) dut (
        .CLK(CLK), .RST_N(RST_N), .FLUSH(FLUSH),
        .PUSH(PUSH), .PUSH_DATA(PUSH_DATA), .PUSH_READY(PUSH_READY),
        .POP_VALID(POP_VALID), .POP_DATA(POP_DATA), .POP(POP),
        .COUNT(COUNT),
        .RF_RE(RF_RE), .RF_RADDR(RF_RADDR), .RF_RDATA(RF_RDATA),
        .RF_WE(RF_WE), .RF_WADDR(RF_WADDR), .RF_WDATA(RF_WDATA)
    );

    always #5 CLK = ~CLK;

    // Behavioural 1w1r RF: registered read, holds last read value while RE=0.
    always @(posedge CLK) begin
        if (RF_WE) rf_mem[RF_WADDR] <= RF_WDATA;
        if (RF_RE) rf_rdata_r <= rf_mem[RF_RADDR];
    end
    assign RF_RDATA = rf_rdata_r;

    int n_checks = 0;
    int n_pass   = 0;

    // Reference model: entries held in RF, whether a head is staged, data order.
    int            m_rf   = 0;
    bit            m_out  = 1'b0;
    int            m_wcnt = 0;
    int            m_rcnt = 0;
    logic [DW-1:0] exp_q[$];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    endtask

    task automatic model_reset();
        m_rf = 0; m_out = 1'b0; m_wcnt = 0; m_rcnt = 0;
        exp_q.delete();
    endtask

    // One clock cycle, entered and left just after a falling edge.
    task automatic step(input bit push, input logic [DW-1:0] d, input bit pop, input bit flush);
        bit acc_w, acc_p, move;
        check("push_ready", PUSH_READY, (m_rf < DEPTH));
        check("pop_valid", POP_VALID, m_out);
        check("count", COUNT, m_rf + int'(m_out));
        PUSH = push; PUSH_DATA = d; POP = pop; FLUSH = flush;
        acc_w = push && (m_rf < DEPTH) && !flush;
        acc_p = pop && m_out && !flush;
        move  = !flush && (m_rf > 0) && (!m_out || acc_p);
        #1;
        check("rf_we", RF_WE, acc_w);
        check("rf_re", RF_RE, move);
        if (acc_w) begin
            check("rf_waddr", RF_WADDR, m_wcnt % DEPTH);
            check("rf_wdata", RF_WDATA, d);
            exp_q.push_back(d);
        end
        if (move) check("rf_raddr", RF_RADDR, m_rcnt % DEPTH);
        @(posedge CLK);
        if (flush) begin
            model_reset();
        end else begin
            m_rf  = m_rf + int'(acc_w) - int'(move);
            m_wcnt += int'(acc_w);
            m_rcnt += int'(move);
            m_out = move ? 1'b1 : (acc_p ? 1'b0 : m_out);
        end
        @(negedge CLK);
    endtask

    // Monitor: on every accepted pop, the head must match the oldest expected entry.
    always @(negedge CLK) begin
        #2;
        if (RST_N && POP_VALID && POP && !FLUSH) begin
            if (exp_q.size() == 0) check("scoreboard_empty", 64'd1, 64'd0);
            else check("pop_data", POP_DATA, exp_q.pop_front());
        end
    end

    initial begin
        int base;
        repeat (3) @(negedge CLK);
        RST_N = 1'b1;
        @(negedge CLK);

        // Single entry latency
        step(1'b1, 32'hDEADBEEF, 1'b0, 1'b0);
        step(1'b0, '0, 1'b0, 1'b0);
        check("single_valid", POP_VALID, 1'b1);
        check("single_data", POP_DATA, 32'hDEADBEEF);
        check("single_count", COUNT, 5'd1);
        step(1'b0, '0, 1'b1, 1'b0);
        check("single_after_valid", POP_VALID, 1'b0);
        check("single_after_count", COUNT, 5'd0);

        // Fill to capacity, overflow push ignored, then drain
        for (int i = 0; i < 10; i++) step(1'b1, DW'(i), 1'b0, 1'b0);
        check("fill_count", COUNT, 5'd9);
        check("fill_ready", PUSH_READY, 1'b0);
        for (int i = 0; i < 20 && POP_VALID; i++) step(1'b0, '0, 1'b1, 1'b0);
        check("drain_empty", POP_VALID, 1'b0);
        check("drain_sb_empty", exp_q.size(), 0);

        // Streaming across pointer wraps
        for (int i = 0; i < 3; i++) step(1'b1, 32'h100 + DW'(i), 1'b0, 1'b0);
        base = int'(COUNT);
        for (int i = 0; i < 40; i++) begin
            check("stream_valid", POP_VALID, 1'b1);
            check("stream_count", COUNT, base);
            step(1'b1, 32'h200 + DW'(i), 1'b1, 1'b0);
        end
        for (int i = 0; i < 20 && POP_VALID; i++) step(1'b0, '0, 1'b1, 1'b0);

        // Flush with traffic in the same cycle
        for (int i = 0; i < 5; i++) step(1'b1, 32'h300 + DW'(i), 1'b0, 1'b0);
        check("preflush_count", COUNT, 5'd5);
        step(1'b1, 32'h3FF, 1'b1, 1'b1);
        check("flush_count", COUNT, 5'd0);
        check("flush_valid", POP_VALID, 1'b0);
        check("flush_ready", PUSH_READY, 1'b1);
        step(1'b1, 32'hA5, 1'b0, 1'b0);
        step(1'b0, '0, 1'b0, 1'b0);
        check("post_flush_data", POP_DATA, 32'hA5);
        step(1'b0, '0, 1'b1, 1'b0);

        // Stray pop when empty, then full push with simultaneous pop
        step(1'b0, '0, 1'b1, 1'b0);
        check("stray_count", COUNT, 5'd0);
        for (int i = 0; i < 9; i++) step(1'b1, 32'h400 + DW'(i), 1'b0, 1'b0);
        check("full_count", COUNT, 5'd9);
        step(1'b1, 32'h4FF, 1'b1, 1'b0);
        check("full_pushpop_count", COUNT, 5'd8);

        // Asynchronous reset mid-traffic
        PUSH = 1'b0; POP = 1'b0; FLUSH = 1'b0;
        RST_N = 1'b0;
        #1;
        check("rst_ready", PUSH_READY, 1'b1);
        check("rst_valid", POP_VALID, 1'b0);
        check("rst_count", COUNT, 5'd0);
        check("rst_we", RF_WE, 1'b0);
        check("rst_re", RF_RE, 1'b0);
        model_reset();
        @(negedge CLK);
        RST_N = 1'b1;
        @(negedge CLK);
        for (int i = 0; i < 3; i++) step(1'b0, '0, 1'b0, 1'b0);

        // Randomized traffic
        for (int i = 0; i < 800; i++) begin
            step(bit'($urandom_range(0, 99) < 60), $urandom(),
                 bit'($urandom_range(0, 99) < 50), bit'($urandom_range(0, 99) < 2));
        end
        for (int i = 0; i < 20 && POP_VALID; i++) step(1'b0, '0, 1'b1, 1'b0);
        check("final_sb_empty", exp_q.size(), 0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
